fir_bank_controller: RTL and testbench

FIR_BANK_CONTROLLER -- requirements
Module: fir_bank_controller

---
 rtl/fir_bank_controller.sv | 165 ++++++++++++++++
 tb/tb_fir_bank_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_bank_controller.sv
// Sequencer that loads 78 triangular-packed coefficients into a filter bank,
// streams 4096 samples, then waits for the bank's order decision or times out.
module fir_bank_controller (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iEnable,
    input  logic               iStart,
    output logic [6:0]         oCoeffAddr,
    input  logic [11:0]        iCoeffData,
    output logic [11:0]        oSampleAddr,
    input  logic signed [15:0] iSampleData,
    output logic               oBankReset,
    output logic               oLoad,
    output logic [3:0]         oM,
    output logic [11:0]        oCoeff,
    output logic               oValid,
    output logic signed [15:0] oSample,
    input  logic               iBankDone,
    input  logic [3:0]         iBestPredictor,
    output logic               oBusy,
    output logic               oDone,
    output logic               oTimeout,
    output logic [3:0]         oBestOrder
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, STREAM, WAIT, SETTLE} state_t;

    localparam logic [11:0] LAST_COEFF  = 12'd77;
    localparam logic [11:0] LAST_SAMPLE = 12'd4095;

    state_t      state, state_next;
    logic [11:0] addr_cnt;
    logic [3:0]  cur_m, cur_k, pend_m;
    logic        coeff_rd, sample_rd;
    logic        done_seen;
    logic [7:0]  tmo_cnt;
    logic [1:0]  settle_cnt;

    logic        clear_go, coeff_issue, sample_issue;
    logic        wait_step, tmo_hit, settle_step, settle_done;

    always_ff @(posedge iClock) begin
        if (iReset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (iEnable) begin
            case (state)
                IDLE:    if (iStart) state_next = CLEAR;
                CLEAR:   state_next = LOAD;
                LOAD:    if (addr_cnt == LAST_COEFF) state_next = STREAM;
                STREAM:  if (addr_cnt == LAST_SAMPLE) state_next = WAIT;
                WAIT: begin
                    if (done_seen || iBankDone) state_next = SETTLE;
                    else if (tmo_cnt == 8'hFF)  state_next = IDLE;
                end
                SETTLE:  if (settle_cnt == 2'd3) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        clear_go     = iEnable && (state == CLEAR);
        coeff_issue  = iEnable && (state == LOAD);
        sample_issue = iEnable && (state == STREAM);
        wait_step    = iEnable && (state == WAIT) && !(done_seen || iBankDone);
        tmo_hit      = wait_step && (tmo_cnt == 8'hFF);
        settle_step  = iEnable && (state == SETTLE);
        settle_done  = settle_step && (settle_cnt == 2'd3);
        oBusy        = (state != IDLE);
    end

    // Reads are registered one cycle ahead of their strobe, so a strobe always
    // follows its issue even when iEnable drops in between.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            addr_cnt    <= '0;
            cur_m       <= '0;
            cur_k       <= '0;
            pend_m      <= '0;
            coeff_rd    <= 1'b0;
            sample_rd   <= 1'b0;
            done_seen   <= 1'b0;
            tmo_cnt     <= '0;
            settle_cnt  <= '0;
            oCoeffAddr  <= '0;
            oSampleAddr <= '0;
            oBankReset  <= 1'b0;
            oLoad       <= 1'b0;
            oM          <= '0;
            oCoeff      <= '0;
            oValid      <= 1'b0;
            oSample     <= '0;
            oDone       <= 1'b0;
            oTimeout    <= 1'b0;
            oBestOrder  <= '0;
        end else begin
            oBankReset <= clear_go;
            coeff_rd   <= coeff_issue;
            sample_rd  <= sample_issue;
            oLoad      <= coeff_rd;
            oValid     <= sample_rd;
            oDone      <= 1'b0;
            oTimeout   <= 1'b0;

            if (coeff_rd) begin
                oCoeff <= iCoeffData;
                oM     <= pend_m;
            end
            if (sample_rd) oSample <= iSampleData;

            if (clear_go) begin
                addr_cnt   <= '0;
                cur_m      <= 4'd1;
                cur_k      <= '0;
                done_seen  <= 1'b0;
                tmo_cnt    <= '0;
                settle_cnt <= '0;
            end

            // Order M spans M consecutive addresses; track position within it.
            if (coeff_issue) begin
                oCoeffAddr <= addr_cnt[6:0];
                pend_m     <= cur_m;
                if (cur_k == cur_m - 4'd1) begin
                    cur_m <= cur_m + 4'd1;
                    cur_k <= '0;
                end else begin
                    cur_k <= cur_k + 4'd1;
                end
                addr_cnt <= (addr_cnt == LAST_COEFF) ? '0 : addr_cnt + 12'd1;
            end

            if (sample_issue) begin
                oSampleAddr <= addr_cnt;
                if (addr_cnt != LAST_SAMPLE) addr_cnt <= addr_cnt + 12'd1;
            end

            if (((state == STREAM) || (state == WAIT)) && iBankDone) done_seen <= 1'b1;

            if (wait_step) tmo_cnt <= tmo_cnt + 8'd1;
            if (settle_step) settle_cnt <= settle_cnt + 2'd1;

            if (tmo_hit) begin
                oBestOrder <= '0;
                oTimeout   <= 1'b1;
                oDone      <= 1'b1;
            end

            if (settle_done) begin
                oDone <= 1'b1;
                if ((iBestPredictor >= 4'd1) && (iBestPredictor <= 4'd12)) begin
                    oBestOrder <= iBestPredictor;
                end else begin
                    oBestOrder <= '0;
                    oTimeout   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_bank_controller.sv
// Directed bench for fir_bank_controller: memories return their own address,
// a scoreboard checks every strobe and the block-level timing and results.
module tb_fir_bank_controller;

    logic               iClock, iReset, iEnable, iStart;
    logic [6:0]         oCoeffAddr;
    logic [11:0]        iCoeffData;
    logic [11:0]        oSampleAddr;
    logic signed [15:0] iSampleData;
    logic               oBankReset, oLoad, oValid;
    logic [3:0]         oM;
    logic [11:0]        oCoeff;
    logic signed [15:0] oSample;
    logic               iBankDone;
    logic [3:0]         iBestPredictor;
    logic               oBusy, oDone, oTimeout;
    logic [3:0]         oBestOrder;

    fir_bank_controller dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iStart(iStart),
        .oCoeffAddr(oCoeffAddr), .iCoeffData(iCoeffData),
        .oSampleAddr(oSampleAddr), .iSampleData(iSampleData),
        .oBankReset(oBankReset), .oLoad(oLoad), .oM(oM), .oCoeff(oCoeff),
        .oValid(oValid), .oSample(oSample),
        .iBankDone(iBankDone), .iBestPredictor(iBestPredictor),
        .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout), .oBestOrder(oBestOrder)
    );

    assign iCoeffData  = {5'b0, oCoeffAddr};
    assign iSampleData = {4'b0, oSampleAddr};

    int errors = 0, checks = 0;
    int cyc = 0, t0 = 0;
    bit stall_mode = 0;
    int load_cnt, val_cnt, done_cnt, rst_cnt;
    int first_rst, first_load, last_load, first_val, last_val, done_cyc;
    int done_bo, done_to;
    int m_seen [0:77];

    initial begin
        iClock = 0;
        forever #5 iClock = ~iClock;
    end

    always @(posedge iClock) cyc++;

    initial begin
        iEnable = 1;
        forever begin
            @(posedge iClock);
            #1;
            iEnable = stall_mode ? (cyc % 3 != 2) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Order M holds addresses M(M-1)/2 .. M(M-1)/2+M-1.
    function automatic int order_of(input int k);
        int r = 0;
        for (int m = 1; m <= 12; m++)
            if (k >= m * (m - 1) / 2) r = m;
        return r;
    endfunction

    always @(negedge iClock) begin
        check("load_valid_exclusive", {63'd0, oLoad & oValid}, 64'd0);
        if (oBankReset) begin
            if (rst_cnt == 0) first_rst = cyc;
            rst_cnt++;
        end
        if (oLoad) begin
            check("coeff_value", {52'd0, oCoeff}, 64'(load_cnt));
            check("coeff_order", {60'd0, oM}, 64'(order_of(load_cnt)));
            if (load_cnt < 78) m_seen[load_cnt] = int'(oM);
            if (load_cnt == 0) first_load = cyc;
            last_load = cyc;
            load_cnt++;
        end
        if (oValid) begin
            check("sample_value", 64'(oSample), 64'(val_cnt));
            if (val_cnt == 0) first_val = cyc;
            last_val = cyc;
            val_cnt++;
        end
        if (oDone) begin
            done_cnt++;
            done_cyc = cyc;
            done_bo  = int'(oBestOrder);
            done_to  = int'(oTimeout);
        end
    end

    task automatic tick();
        @(posedge iClock);
        #2;
    endtask

    task automatic clear_counts();
        load_cnt = 0; val_cnt = 0; done_cnt = 0; rst_cnt = 0;
        first_rst = -1; first_load = -1; last_load = -1;
        first_val = -1; last_val = -1; done_cyc = -1; done_bo = -1; done_to = -1;
    endtask

    task automatic start_block();
        int n = 0;
        clear_counts();
        iStart = 1;
        t0 = cyc + 1;
        tick();
        while (!oBusy && n < 10) begin
            t0 = cyc + 1;
            tick();
            n++;
        end
        iStart = 0;
        check("start_accepted", {63'd0, oBusy}, 64'd1);
    endtask

    task automatic wait_until_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_done();
        iBankDone = 1;
        tick();
        iBankDone = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", {63'd0, done_cnt > 0}, 64'd1);
    endtask

    task automatic wait_valids(input int target, input int budget);
        int n = 0;
        while (val_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("valid_progress", {63'd0, val_cnt >= target}, 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {3'd0, oBankReset, oLoad, oM, oCoeff, oValid, oSample, oBusy,
                     oDone, oTimeout, oBestOrder, oCoeffAddr, oSampleAddr}, 64'd0);
    endtask

    initial begin
        iReset = 1; iStart = 0; iBankDone = 0; iBestPredictor = 7;
        clear_counts();
        repeat (3) tick();
        check_all_zero("reset_outputs");
        iReset = 0;
        tick();

        // Nominal block, full timing
        iBestPredictor = 7;
        start_block();
        wait_until_cyc(t0 + 4099);
        pulse_done();
        wait_done(500);
        check("nom_bankreset_count", 64'(rst_cnt), 64'd1);
        check("nom_bankreset_time", 64'(first_rst - t0), 64'd1);
        check("nom_first_load", 64'(first_load - t0), 64'd3);
        check("nom_last_load", 64'(last_load - t0), 64'd80);
        check("nom_first_valid", 64'(first_val - t0), 64'd81);
        check("nom_last_valid", 64'(last_val - t0), 64'd4176);
        check("nom_load_count", 64'(load_cnt), 64'd78);
        check("nom_valid_count", 64'(val_cnt), 64'd4096);
        check("nom_done_time", 64'(done_cyc - t0), 64'd4180);
        check("nom_best_order", 64'(done_bo), 64'd7);
        check("nom_timeout", 64'(done_to), 64'd0);
        check("pin_m0", 64'(m_seen[0]), 64'd1);
        check("pin_m1", 64'(m_seen[1]), 64'd2);
        check("pin_m2", 64'(m_seen[2]), 64'd2);
        check("pin_m3", 64'(m_seen[3]), 64'd3);
        check("pin_m65", 64'(m_seen[65]), 64'd11);
        check("pin_m66", 64'(m_seen[66]), 64'd12);
        check("pin_m77", 64'(m_seen[77]), 64'd12);
        repeat (10) tick();
        check("nom_done_once", 64'(done_cnt), 64'd1);
        check("nom_order_held", {60'd0, oBestOrder}, 64'd7);
        check("nom_idle", {63'd0, oBusy}, 64'd0);

        // Enable dropped every third cycle
        iBestPredictor = 5;
        stall_mode = 1;
        start_block();
        wait_valids(4000, 8000);
        pulse_done();
        wait_done(2000);
        stall_mode = 0;
        repeat (5) tick();
        check("stall_load_count", 64'(load_cnt), 64'd78);
        check("stall_valid_count", 64'(val_cnt), 64'd4096);
        check("stall_done_once", 64'(done_cnt), 64'd1);
        check("stall_best_order", 64'(done_bo), 64'd5);
        check("stall_timeout", 64'(done_to), 64'd0);

        // Timeout: bank never reports done
        start_block();
        wait_done(5000);
        check("tmo_done_time", 64'(done_cyc - t0), 64'd4431);
        check("tmo_timeout", 64'(done_to), 64'd1);
        check("tmo_best_order", 64'(done_bo), 64'd0);
        check("tmo_valid_count", 64'(val_cnt), 64'd4096);

        // Reset mid-stream, then restart
        iBestPredictor = 9;
        start_block();
        wait_valids(1000, 2000);
        iReset = 1;
        tick();
        iReset = 0;
        check_all_zero("midreset_outputs");
        done_cnt = 0; load_cnt = 0; val_cnt = 0;
        repeat (300) tick();
        check("midreset_no_done", 64'(done_cnt), 64'd0);
        check("midreset_no_strobes", 64'(load_cnt + val_cnt), 64'd0);
        check("midreset_idle", {63'd0, oBusy}, 64'd0);
        start_block();
        wait_until_cyc(t0 + 2);
        check("restart_bankreset_time", 64'(first_rst - t0), 64'd1);
        check("restart_addr0", {57'd0, oCoeffAddr}, 64'd0);
        tick();
        check("restart_addr1", {57'd0, oCoeffAddr}, 64'd1);
        wait_until_cyc(t0 + 4099);
        pulse_done();
        wait_done(500);
        check("restart_load_count", 64'(load_cnt), 64'd78);
        check("restart_valid_count", 64'(val_cnt), 64'd4096);
        check("restart_best_order", 64'(done_bo), 64'd9);

        // iStart during LOAD and WAIT is ignored
        iBestPredictor = 12;
        start_block();
        wait_until_cyc(t0 + 20);
        iStart = 1; tick(); iStart = 0;
        wait_until_cyc(t0 + 4200);
        iStart = 1; tick(); iStart = 0;
        wait_until_cyc(t0 + 4299);
        pulse_done();
        wait_done(500);
        repeat (20) tick();
        check("ign_done_time", 64'(done_cyc - t0), 64'd4304);
        check("ign_done_once", 64'(done_cnt), 64'd1);
        check("ign_bankreset_once", 64'(rst_cnt), 64'd1);
        check("ign_load_count", 64'(load_cnt), 64'd78);
        check("ign_valid_count", 64'(val_cnt), 64'd4096);
        check("ign_best_order", 64'(done_bo), 64'd12);
        check("ign_idle", {63'd0, oBusy}, 64'd0);

        // Out-of-range predictor
        iBestPredictor = 13;
        start_block();
        wait_until_cyc(t0 + 4099);
        pulse_done();
        wait_done(500);
        check("bad_pred_order", 64'(done_bo), 64'd0);
        check("bad_pred_timeout", 64'(done_to), 64'd1);
        check("bad_pred_done_time", 64'(done_cyc - t0), 64'd4180);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
